// File: rtl/seq_divider_if.sv
// ----------------------------------------------------------------------------
// seq_divider_if
// Request/response bundle for the sequential sign-magnitude divider.
//   start     : request a division (sampled only while the divider is idle)
//   dividend  : 32-bit sign-magnitude operand (bit31 sign, bits30:0 magnitude)
//   divisor   : 16-bit sign-magnitude operand (bit15 sign, bits14:0 magnitude)
//   quotient  : 16-bit sign-magnitude result
//   remainder : 16-bit sign-magnitude result
//   busy      : division in progress
//   done      : one-cycle pulse when results are valid
//   dz / ovf  : divide-by-zero / quotient-overflow flags, valid with done
// master = requester, slave = divider.
// ----------------------------------------------------------------------------
interface seq_divider_if;

  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        dz;
  logic        ovf;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  quotient,
    input  remainder,
    input  busy,
    input  done,
    input  dz,
    input  ovf
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output quotient,
    output remainder,
    output busy,
    output done,
    output dz,
    output ovf
  );

endinterface : seq_divider_if

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Sequential restoring divider, 31-bit magnitude by 15-bit magnitude, giving
// a 15-bit quotient magnitude and 15-bit remainder magnitude in 15 steps.
// Operands and results are sign-magnitude; zero results never carry a sign.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if.slave (start/operands in, results/status out)
// ----------------------------------------------------------------------------
module seq_divider (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int unsigned DVD_W  = 32;
  localparam int unsigned DVS_W  = 16;
  localparam int unsigned MAG_W  = 15;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STEPS  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Architectural state
  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [MAG_W-1:0]   pr_q,     pr_d;      // partial remainder
  logic [MAG_W-1:0]   dvd_q,    dvd_d;     // low dividend bits out, quotient bits in
  logic [MAG_W-1:0]   dvs_q,    dvs_d;     // divisor magnitude
  logic               sq_q,     sq_d;      // quotient sign
  logic               sr_q,     sr_d;      // remainder sign
  logic [DVS_W-1:0]   quot_q,   quot_d;
  logic [DVS_W-1:0]   rem_q,    rem_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               dz_q,     dz_d;
  logic               ovf_q,    ovf_d;

  // One restoring step: 16-bit trial value, compare, subtract or restore
  logic [MAG_W:0]     shifted_c;
  logic               step_ok_c;
  logic [MAG_W-1:0]   pr_step_c;
  logic [MAG_W-1:0]   dvd_step_c;

  // Start-time operand classification
  logic [MAG_W-1:0]   in_dvs_mag_c;
  logic [MAG_W:0]     in_dvd_hi_c;

  always_comb begin
    shifted_c  = {pr_q, dvd_q[MAG_W-1]};
    step_ok_c  = (shifted_c >= {1'b0, dvs_q});
    pr_step_c  = step_ok_c ? MAG_W'(shifted_c - {1'b0, dvs_q})
                           : shifted_c[MAG_W-1:0];
    dvd_step_c = {dvd_q[MAG_W-2:0], step_ok_c};
  end

  assign in_dvs_mag_c = bus.divisor[MAG_W-1:0];
  assign in_dvd_hi_c  = bus.dividend[DVD_W-2:MAG_W];

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvs_d = in_dvs_mag_c;
          sq_d  = bus.dividend[DVD_W-1] ^ bus.divisor[DVS_W-1];
          sr_d  = bus.dividend[DVD_W-1];
          // Upper dividend bits are below the divisor on the RUN path,
          // so they fit in the 15-bit partial remainder.
          pr_d  = in_dvd_hi_c[MAG_W-1:0];
          dvd_d = bus.dividend[MAG_W-1:0];
          if (in_dvs_mag_c == '0) begin
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            quot_d  = '0;
            rem_d   = '0;
            state_d = FIN;
          end else if (in_dvd_hi_c >= {1'b0, in_dvs_mag_c}) begin
            // Quotient would not fit in 15 bits
            dz_d    = 1'b0;
            ovf_d   = 1'b1;
            quot_d  = '0;
            rem_d   = '0;
            state_d = FIN;
          end else begin
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(STEPS);
            state_d = RUN;
          end
        end
      end

      RUN: begin
        pr_d  = pr_step_c;
        dvd_d = dvd_step_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Sign bits are suppressed on zero magnitudes
          quot_d  = {sq_q & (|dvd_step_c), dvd_step_c};
          rem_d   = {sr_q & (|pr_step_c),  pr_step_c};
          busy_d  = 1'b0;
          state_d = FIN;
        end
      end

      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;

endmodule : seq_divider

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  32  sign-magnitude: bit31 sign, bits30:0 magnitude.
REQ-006 divisor  input  16  sign-magnitude: bit15 sign, bits14:0 magnitude.
REQ-007 quotient  output  16  sign-magnitude result, registered.
REQ-008 remainder  output  16  sign-magnitude result, registered.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  single-cycle pulse when results are valid.
REQ-011 dz  output  1  divide-by-zero flag, valid with done.
REQ-012 ovf  output  1  quotient-overflow flag, valid with done.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-014 In IDLE, start=1 at an edge SHALL capture dividend and divisor into internal registers; later input changes have no effect.
REQ-015 At that edge, if divisor[14:0]==0, the block SHALL set dz=1, ovf=0, quotient=0 and remainder=0, then go to FIN; this includes the case 16'h8000.
REQ-016 Otherwise, if dividend[30:15] >= divisor[14:0], the block SHALL set ovf=1, dz=0, quotient=0 and remainder=0, then go to FIN.
REQ-017 Otherwise the block SHALL clear dz and ovf, set busy=1, load the iteration counter with 15, and go to RUN.
REQ-018 RUN SHALL perform one restoring-division step per clock:
  - shift the {partial remainder, dividend magnitude} pair left by 1;
  - trial-subtract the divisor magnitude using a 16-bit partial remainder;
  - if the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0;
  - decrement the counter.
REQ-019 After the 15th step, the block SHALL load quotient and remainder and go to FIN; busy falls at this same edge.
REQ-020 quotient[15] SHALL equal dividend[31] XOR divisor[15]; remainder[15] SHALL equal dividend[31].
REQ-021 A zero magnitude SHALL always carry sign bit 0 (no negative zero) on quotient and remainder.
REQ-022 The final remainder magnitude SHALL be less than the divisor magnitude.
REQ-023 Quotient magnitude SHALL be 15 bits.
REQ-024 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 Latency, counted from the start-sampling edge as edge 0:
  - normal division: done is visible after edge 16;
  - dz or ovf: done is visible after edge 1.
REQ-026 start SHALL be ignored in RUN and FIN.
REQ-027 start held high SHALL begin a new division on the first IDLE edge after done.
REQ-028 quotient, remainder, dz and ovf SHALL hold their values until the next accepted start.

Reset
REQ-029 rst_n=0 SHALL immediately force the following, independent of clk, including mid-RUN:
  - state = IDLE;
  - busy, done, dz, ovf = 0;
  - quotient, remainder = 0;
  - counter and internal registers = 0.
REQ-030 An aborted division SHALL produce no done pulse.
REQ-031 The first start after reset deassertion SHALL be accepted normally.

Verification
REQ-032 dividend=32'h00000064, divisor=16'h0007 -> quotient=16'h000E, remainder=16'h0002, dz=0, ovf=0, done 16 cycles after start.
REQ-033 Sign handling:
  - 32'h80000064 / 16'h0007 -> quotient=16'h800E, remainder=16'h8002;
  - 32'h00000064 / 16'h8007 -> quotient=16'h800E, remainder=16'h0002.
REQ-034 Exact maximum: 32'h3FFF0001 / 16'h7FFF -> quotient=16'h7FFF, remainder=16'h0000, ovf=0.
REQ-035 Zero sign: 32'h80000003 / 16'h0007 -> quotient=16'h0000 (sign cleared), remainder=16'h8003.
REQ-036 Error cases:
  - divisor=16'h8000 -> dz=1, quotient=0, remainder=0, done 1 cycle after start;
  - 32'h00038000 / 16'h0007 -> ovf=1, done 1 cycle after start.
REQ-037 Reset and busy behaviour:
  - pulse rst_n low 8 cycles into a RUN -> all outputs 0, no done;
  - a subsequent 100/7 completes correctly;
  - start pulses while busy are ignored.
